// File: rtl/pipelined_adder_nbit_pkg.sv
// pipelined_adder_pkg: default sizing, stage-count helper and the per-stage control payload.
// The payload gains a sub flag when PIPELINED_ADDER_SUB_EN is defined.
package pipelined_adder_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_CHUNK = 2;

    function automatic int calc_stages(input int width, input int chunk);
        return width / chunk;
    endfunction

    typedef struct packed {
`ifdef PIPELINED_ADDER_SUB_EN
        logic sub;
`endif
        logic carry;
    } stage_ctl_t;
endpackage

// File: rtl/pipelined_adder_nbit_chunk.sv
// ripple_adder_chunk: combinational CHUNK-bit ripple adder, one full-adder cell per bit.
module ripple_adder_chunk import pipelined_adder_pkg::*; #(
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic [CHUNK-1:0] a,
    input  logic [CHUNK-1:0] b,
    input  logic             cin,
    output logic [CHUNK-1:0] sum,
    output logic             cout
);
    always_comb begin
        logic c;
        c = cin;
        sum = '0;
        for (int i = 0; i < CHUNK; i++) begin
            sum[i] = a[i] ^ b[i] ^ c;
            c = (a[i] & b[i]) | (c & (a[i] ^ b[i]));
        end
        cout = c;
    end
endmodule

// File: rtl/pipelined_adder_nbit.sv
// pipelined_adder_nbit: CHUNK bits per stage ripple-carry adder with valid/ready and full backpressure.
// Define PIPELINED_ADDER_SUB_EN to add a Sub port that turns the operation into A-B.
module pipelined_adder_nbit import pipelined_adder_pkg::*; #(
    parameter int WIDTH = DEF_WIDTH,
    parameter int CHUNK = DEF_CHUNK
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
`ifdef PIPELINED_ADDER_SUB_EN
    input  logic             Sub,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Sum,
    output logic             Cout,
    output logic [WIDTH:0]   Out
);
    localparam int STAGES = calc_stages(WIDTH, CHUNK);

    if (WIDTH % CHUNK != 0) begin : g_chk
        $error("pipelined_adder_nbit: WIDTH must be a multiple of CHUNK");
    end

    logic [STAGES-1:0] r_valid;
    logic [WIDTH-1:0]  r_as [STAGES];
    logic [WIDTH-1:0]  r_b  [STAGES];
    stage_ctl_t        r_ctl [STAGES];

    logic [STAGES:0]   w_vld;
    logic [STAGES-1:0] w_rdy, w_inv, w_co;
    logic [WIDTH-1:0]  w_as [STAGES+1];
    logic [WIDTH-1:0]  w_b  [STAGES];
    stage_ctl_t        w_ctl [STAGES+1];
    logic [CHUNK-1:0]  w_s  [STAGES];
    logic              w_sub_in;

`ifdef PIPELINED_ADDER_SUB_EN
    assign w_sub_in = Sub;
`else
    assign w_sub_in = 1'b0;
`endif

    // Index 0 of each w_ array is the input port side; index k+1 is stage k's register.
    always_comb begin
        logic acc;
        w_vld = {r_valid, in_valid};
        w_as[0] = A;
        w_b[0] = B;
        w_ctl[0] = '0;
        w_ctl[0].carry = Cin | w_sub_in;
`ifdef PIPELINED_ADDER_SUB_EN
        w_ctl[0].sub = w_sub_in;
`endif
        for (int k = 0; k < STAGES; k++) begin
            w_as[k+1] = r_as[k];
            w_ctl[k+1] = r_ctl[k];
        end
        for (int k = 1; k < STAGES; k++)
            w_b[k] = r_b[k-1];
        acc = out_ready;
        w_rdy = '0;
        for (int k = STAGES - 1; k >= 0; k--) begin
            acc = acc | ~r_valid[k];
            w_rdy[k] = acc;
        end
        w_inv = '0;
`ifdef PIPELINED_ADDER_SUB_EN
        for (int k = 0; k < STAGES; k++)
            w_inv[k] = w_ctl[k].sub;
`endif
    end

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        ripple_adder_chunk #(.CHUNK(CHUNK)) u_add (
            .a    (w_as[k][CHUNK-1:0]),
            .b    (w_b[k][CHUNK-1:0] ^ {CHUNK{w_inv[k]}}),
            .cin  (w_ctl[k].carry),
            .sum  (w_s[k]),
            .cout (w_co[k])
        );
    end

    // The A word rotates: each stage consumes its low slice and inserts the new sum slice at the top,
    // so after the last stage it holds exactly Sum.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid <= '0;
            for (int k = 0; k < STAGES; k++) begin
                r_as[k] <= '0;
                r_b[k] <= '0;
                r_ctl[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (w_rdy[k]) begin
                    r_valid[k] <= w_vld[k];
                    if (w_vld[k]) begin
                        r_as[k] <= WIDTH'({w_s[k], w_as[k]} >> CHUNK);
                        r_b[k] <= w_b[k] >> CHUNK;
                        r_ctl[k] <= w_ctl[k];
                        r_ctl[k].carry <= w_co[k];
                    end
                end
            end
        end
    end

    assign in_ready = w_rdy[0];
    assign out_valid = w_vld[STAGES];
    assign Sum = w_as[STAGES];
    assign Cout = w_ctl[STAGES].carry;
    assign Out = {Cout, Sum};
endmodule

// File: tb/tb_pipelined_adder_nbit.sv
// tb_pipelined_adder_nbit: scoreboard bench; accepted inputs push a reference result, a monitor pops and compares.
module tb_pipelined_adder_nbit;
    localparam int W = 8;

    logic clk = 0, rst = 0, in_valid = 0, in_ready, Cin = 0, out_valid, out_ready = 1, Cout, sub = 0;
    logic [W-1:0] A = '0, B = '0, Sum;
    logic [W:0] Out;

    typedef struct {
        logic [W:0] v;
        int         c;
        bit         l;
    } exp_t;

    exp_t q[$];
    int total = 0, bad = 0, cyc = 0, n_acc = 0, n0 = 0;
    bit lat_on = 0, rand_mode = 0, stall_prev = 0;
    logic [W:0] out_prev = '0;

    pipelined_adder_nbit #(.WIDTH(W), .CHUNK(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Cin       (Cin),
`ifdef PIPELINED_ADDER_SUB_EN
        .Sub       (sub),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Sum       (Sum),
        .Cout      (Cout),
        .Out       (Out)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;
    always @(posedge clk) if (rand_mode) begin #1; out_ready = ($urandom % 4) != 0; end

    function automatic logic [W:0] model(input logic [W-1:0] a, b, input logic c, s);
        return s ? {1'b0, a} + {1'b0, ~b} + (W+1)'(1) : {1'b0, a} + {1'b0, b} + (W+1)'(c);
    endfunction

    function automatic void check(input string n, input logic [31:0] got, exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", n, got, exp);
        end
    endfunction

    function automatic logic [W-1:0] pick();
        int r = $urandom % 4;
        return r == 0 ? '0 : r == 1 ? '1 : W'($urandom);
    endfunction

    always @(negedge clk)
        if (!rst && in_valid && in_ready) begin
            q.push_back('{model(A, B, Cin, sub), cyc, lat_on});
            n_acc++;
        end

    always @(negedge clk) begin
        if (rst) stall_prev = 0;
        else begin
            if (stall_prev) begin
                check("stall_hold", Out, out_prev);
                check("stall_valid", out_valid, 1);
            end
            if (out_valid && out_ready) begin
                if (q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL unexpected_out got=%0h exp=none", Out);
                end else begin
                    exp_t e;
                    e = q.pop_front();
                    check("out", Out, e.v);
                    check("cout_sum", {Cout, Sum}, e.v);
                    if (e.l) check("latency", cyc - e.c, 4);
                end
            end
            stall_prev = out_valid && !out_ready;
            out_prev = Out;
        end
    end

    task automatic send(input logic [W-1:0] a, b, input logic c, s);
        int t = 0;
        A = a; B = b; Cin = c; sub = s; in_valid = 1;
        @(negedge clk);
        while (!in_ready && t < 100) begin @(negedge clk); t++; end
        if (t >= 100) begin
            total++;
            bad++;
            $display("FAIL send_timeout in_ready=%0b exp=1", in_ready);
        end
        @(posedge clk);
        #1 in_valid = 0;
    endtask

    task automatic wait_idle();
        int t = 0;
        while ((q.size() != 0 || out_valid) && t < 60) begin @(posedge clk); #1; t++; end
        if (t >= 60) begin
            total++;
            bad++;
            $display("FAIL drain_timeout pending=%0d exp=0", q.size());
        end
        repeat (3) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        #1 rst = 1;
        #1;
        check("rst_out_valid", out_valid, 0);
        check("rst_out", Out, 0);
        @(posedge clk);
        #3 rst = 0;
        @(posedge clk);
        #1 check("in_ready_after_rst", in_ready, 1);

        lat_on = 1;
        send(8'hFF, 8'h01, 0, 0);
        wait_idle();
        send(8'h12, 8'h34, 0, 0);
        send(8'h80, 8'h80, 0, 0);
        send(8'h0F, 8'h01, 1, 0);
        send(8'hAA, 8'h55, 0, 0);
        wait_idle();

        lat_on = 0;
        n0 = n_acc;
        out_ready = 0;
        A = W'($urandom); B = W'($urandom); Cin = 1'($urandom); in_valid = 1;
        repeat (8) begin
            @(posedge clk);
            #1 A = W'($urandom); B = W'($urandom); Cin = 1'($urandom);
        end
        check("bp_accepted", n_acc - n0, 4);
        check("bp_in_ready", in_ready, 0);
        in_valid = 0;
        out_ready = 1;
        wait_idle();

        lat_on = 1;
        send(8'h11, 8'h22, 0, 0);
        send(8'h33, 8'h44, 1, 0);
        send(8'hF0, 8'h0F, 1, 0);
        #2 rst = 1;
        q.delete();
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_out", Out, 0);
        @(posedge clk);
        #3 rst = 0;
        @(posedge clk);
        #1 check("in_ready_after_midrst", in_ready, 1);
        send(8'h9C, 8'h7B, 1, 0);
        wait_idle();
        repeat (8) @(posedge clk);
        #1;

`ifdef PIPELINED_ADDER_SUB_EN
        send(8'h05, 8'h07, 0, 1);
        send(8'h07, 8'h05, 0, 1);
        wait_idle();
`endif

        lat_on = 0;
        rand_mode = 1;
        repeat (80) begin
            if ($urandom % 3 == 0) begin
                @(posedge clk);
                #1;
            end else begin
`ifdef PIPELINED_ADDER_SUB_EN
                send(pick(), pick(), 1'($urandom), 1'($urandom));
`else
                send(pick(), pick(), 1'($urandom), 0);
`endif
            end
        end
        rand_mode = 0;
        @(posedge clk);
        #2 out_ready = 1;
        wait_idle();
        check("queue_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
